// File: rtl/regfile_dumper_pkg.sv
// Shared debug package: dump FSM states and the default architectural register count.
package regfile_dumper_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StSend,
        StDone
    } dump_state_e;

    localparam int unsigned DefaultNumRegs = 32;

endpackage

// File: rtl/regfile_dumper.sv
// Register file dump engine: walks x0..x(NUM_REGS-1) through the combinational debug read
// port and streams each snapshot on a valid/ready interface.
// Optional feature macro REGFILE_DUMPER_CHECKSUM_EN appends a checksum word (sum of all
// captured words mod 2^DW) with index NUM_REGS.
module regfile_dumper
    import regfile_dumper_pkg::*;
#(
    parameter int unsigned NUM_REGS = DefaultNumRegs,
    parameter int unsigned AW       = 5,
    parameter int unsigned DW       = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    output logic          o_busy,
    output logic [AW-1:0] o_dbg_addr,
    input  logic [DW-1:0] i_dbg_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [DW-1:0] o_data,
    output logic [AW:0]   o_idx,
    output logic          o_last,
    output logic          o_done
);

    localparam logic [AW:0] LastRegIdx = (AW+1)'(NUM_REGS - 1);
`ifdef REGFILE_DUMPER_CHECKSUM_EN
    localparam logic [AW:0] FinalIdx = (AW+1)'(NUM_REGS);
`else
    localparam logic [AW:0] FinalIdx = LastRegIdx;
`endif

    dump_state_e   state_q, state_d;
    logic [AW:0]   idx_q, idx_d;
    logic [DW-1:0] data_q, data_d;
    logic [DW-1:0] captured;

`ifdef REGFILE_DUMPER_CHECKSUM_EN
    logic [DW-1:0] acc_q, acc_d;
`endif

    // x0 is hardwired to zero, so ignore whatever the debug port returns for it.
    assign captured = (idx_q == '0) ? '0 : i_dbg_data;

    // Next-state logic for the walk: READ samples, SEND holds the snapshot until accepted.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d = StRead;
                    idx_d   = '0;
                end
            end
            StRead: begin
                data_d  = captured;
                state_d = StSend;
            end
            StSend: begin
                if (i_ready) begin
                    if (idx_q == FinalIdx) begin
                        state_d = StDone;
`ifdef REGFILE_DUMPER_CHECKSUM_EN
                    end else if (idx_q == LastRegIdx) begin
                        // Checksum word needs no register read; go straight back to SEND.
                        idx_d  = FinalIdx;
                        data_d = acc_q;
`endif
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StRead;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, index and snapshot registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

`ifdef REGFILE_DUMPER_CHECKSUM_EN
    // Accumulator next-state: cleared on an accepted start, adds each captured word.
    always_comb begin
        acc_d = acc_q;
        if (state_q == StIdle && i_start) begin
            acc_d = '0;
        end else if (state_q == StRead) begin
            acc_d = acc_q + captured;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`endif

    // All outputs decode from registered state, so o_valid never depends on i_ready.
    always_comb begin
        o_dbg_addr = idx_q[AW-1:0];
        o_valid    = (state_q == StSend);
        o_data     = data_q;
        o_idx      = idx_q;
        o_last     = (state_q == StSend) && (idx_q == FinalIdx);
        o_done     = (state_q == StDone);
        o_busy     = (state_q != StIdle);
    end

endmodule

// File: tb/tb_regfile_dumper.sv
// Directed self-checking bench for regfile_dumper (honours REGFILE_DUMPER_CHECKSUM_EN).
module tb_regfile_dumper;

`ifdef REGFILE_DUMPER_CHECKSUM_EN
    localparam int NWORDS   = 33;
    localparam int DONE_CYC = 66;
`else
    localparam int NWORDS   = 32;
    localparam int DONE_CYC = 65;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic        o_busy;
    logic [4:0]  o_dbg_addr;
    logic [31:0] i_dbg_data;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_data;
    logic [5:0]  o_idx;
    logic        o_last;
    logic        o_done;

    logic [31:0] regs [32];
    int n_checks = 0;
    int n_fail   = 0;

    regfile_dumper dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .o_busy     (o_busy),
        .o_dbg_addr (o_dbg_addr),
        .i_dbg_data (i_dbg_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_idx      (o_idx),
        .o_last     (o_last),
        .o_done     (o_done)
    );

    always #5 clk = ~clk;

    // Register file model: combinational debug read.
    always_comb i_dbg_data = regs[o_dbg_addr];

    function automatic logic [31:0] exp_data(input int k);
        if (k == 0) return 32'h0;
        if (k < 32) return 32'h1000_0000 + k;
        return 32'hF000_01F0;
    endfunction

    task automatic preload();
        regs[0] = 32'hDEAD_BEEF;
        for (int n = 1; n < 32; n++) regs[n] = 32'h1000_0000 + n;
    endtask

    // Pulse i_start for one edge; returns at the negedge of cycle N+1.
    task automatic kick();
        @(negedge clk);
        i_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_start = 1'b0;
        i_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({o_busy, o_valid, o_last, o_done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: busy/valid/last/done=%b required 0000",
                     {o_busy, o_valid, o_last, o_done});
        end
        n_checks++;
        if (o_data !== 32'h0 || o_idx !== 6'd0 || o_dbg_addr !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_values: data=%h idx=%0d addr=%0d required 0/0/0",
                     o_data, o_idx, o_dbg_addr);
        end
    endtask

    task automatic test_full_dump();
        int k = 0;
        int cyc = 1;
        bit done = 1'b0;
        i_ready = 1'b1;
        kick();
        while (!done && cyc < 400) begin
            if (o_valid && i_ready) begin
                n_checks++;
                if (o_idx !== k[5:0] || o_data !== exp_data(k) || o_last !== (k == NWORDS-1)) begin
                    n_fail++;
                    $display("FAIL full_word: idx=%0d data=%h last=%b required idx=%0d data=%h last=%b",
                             o_idx, o_data, o_last, k, exp_data(k), (k == NWORDS-1));
                end
                k++;
            end
            if (o_done) begin
                done = 1'b1;
                n_checks++;
                if (cyc !== DONE_CYC) begin
                    n_fail++;
                    $display("FAIL full_done_cycle: got %0d required %0d", cyc, DONE_CYC);
                end
            end
            @(posedge clk); cyc++;
            @(negedge clk);
        end
        n_checks++;
        if (!done || k !== NWORDS) begin
            n_fail++;
            $display("FAIL full_count: done=%b words=%0d required 1/%0d", done, k, NWORDS);
        end
        n_checks++;
        if (o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL full_idle: busy=%b required 0", o_busy);
        end
    endtask

    task automatic test_stall();
        int k = 0;
        int cyc = 1;
        int stall = 0;
        bit done = 1'b0;
        kick();
        while (!done && cyc < 400) begin
            i_ready = 1'b1;
            if (o_valid && o_idx == 6'd5 && stall < 10) begin
                i_ready = 1'b0;
                if (stall == 2) regs[5] = 32'h5555_5555;
                stall++;
                n_checks++;
                if (o_valid !== 1'b1 || o_data !== 32'h1000_0005) begin
                    n_fail++;
                    $display("FAIL stall_hold: valid=%b data=%h required 1/10000005", o_valid, o_data);
                end
            end
            if (o_valid && i_ready) begin
                n_checks++;
                if (o_idx !== k[5:0] || o_data !== exp_data(k)) begin
                    n_fail++;
                    $display("FAIL stall_word: idx=%0d data=%h required idx=%0d data=%h",
                             o_idx, o_data, k, exp_data(k));
                end
                k++;
            end
            if (o_done) done = 1'b1;
            @(posedge clk); cyc++;
            @(negedge clk);
        end
        n_checks++;
        if (!done || k !== NWORDS || stall !== 10) begin
            n_fail++;
            $display("FAIL stall_count: done=%b words=%0d stalls=%0d required 1/%0d/10",
                     done, k, stall, NWORDS);
        end
        preload();
    endtask

    task automatic test_start_ignored();
        int k = 0;
        int dones = 0;
        bit pulsed = 1'b0;
        i_ready = 1'b1;
        kick();
        for (int cyc = 1; cyc < 200; cyc++) begin
            i_start = 1'b0;
            if (!pulsed && o_valid && o_idx == 6'd12) begin
                i_start = 1'b1;
                pulsed = 1'b1;
            end
            if (o_valid && i_ready) begin
                n_checks++;
                if (o_idx !== k[5:0] || o_data !== exp_data(k)) begin
                    n_fail++;
                    $display("FAIL ignore_word: idx=%0d data=%h required idx=%0d data=%h",
                             o_idx, o_data, k, exp_data(k));
                end
                k++;
            end
            if (o_done) dones++;
            @(posedge clk);
            @(negedge clk);
        end
        i_start = 1'b0;
        n_checks++;
        if (dones !== 1 || k !== NWORDS || !pulsed) begin
            n_fail++;
            $display("FAIL ignore_count: dones=%0d words=%0d required 1/%0d", dones, k, NWORDS);
        end
    endtask

    task automatic test_reset_mid();
        int cyc = 1;
        int extra = 0;
        i_ready = 1'b1;
        kick();
        while (!(o_valid && o_idx == 6'd20) && cyc < 200) begin
            @(posedge clk); cyc++;
            @(negedge clk);
        end
        n_checks++;
        if (!(o_valid && o_idx == 6'd20)) begin
            n_fail++;
            $display("FAIL rstmid_reach: idx=%0d valid=%b required 20/1", o_idx, o_valid);
        end
        i_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        i_ready = 1'b1;
        n_checks++;
        if ({o_busy, o_valid, o_last, o_done} !== 4'b0000 || o_data !== 32'h0 ||
            o_idx !== 6'd0 || o_dbg_addr !== 5'd0) begin
            n_fail++;
            $display("FAIL rstmid_values: flags=%b data=%h idx=%0d addr=%0d required 0000/0/0/0",
                     {o_busy, o_valid, o_last, o_done}, o_data, o_idx, o_dbg_addr);
        end
        for (int i = 0; i < 8; i++) begin
            if (o_valid || o_done || o_busy) extra++;
            @(posedge clk);
            @(negedge clk);
        end
        n_checks++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL rstmid_quiet: active cycles=%0d required 0", extra);
        end
        kick();
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (o_valid !== 1'b1 || o_idx !== 6'd0 || o_data !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmid_restart: valid=%b idx=%0d data=%h required 1/0/0",
                     o_valid, o_idx, o_data);
        end
        cyc = 0;
        while (!o_done && cyc < 200) begin
            @(posedge clk); cyc++;
            @(negedge clk);
        end
        n_checks++;
        if (o_done !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_finish: done=%b required 1", o_done);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_toggle_ready();
        int k = 0;
        int cyc = 1;
        bit done = 1'b0;
        kick();
        while (!done && cyc < 400) begin
            i_ready = cyc[0];
            if (o_valid && i_ready) begin
                n_checks++;
                if (o_idx !== k[5:0] || o_data !== exp_data(k) || o_last !== (k == NWORDS-1)) begin
                    n_fail++;
                    $display("FAIL toggle_word: idx=%0d data=%h last=%b required idx=%0d data=%h",
                             o_idx, o_data, o_last, k, exp_data(k));
                end
                k++;
            end
            if (o_done) done = 1'b1;
            @(posedge clk); cyc++;
            @(negedge clk);
        end
        n_checks++;
        if (!done || k !== NWORDS) begin
            n_fail++;
            $display("FAIL toggle_count: done=%b words=%0d required 1/%0d", done, k, NWORDS);
        end
    endtask

    initial begin
        preload();
        test_reset();
        test_full_dump();
        test_stall();
        test_start_ignored();
        test_reset_mid();
        test_toggle_ready();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
